// File: rtl/iterative_alu.sv
// Execute-stage ALU. Single-cycle arithmetic, logic and compare operations.
// Shifts run one bit per cycle, so there is no barrel shifter. Requests and
// results both use valid/ready handshakes.
//
// state  | meaning
// IDLE   | ready for a request (o_ready=1)
// SHIFT  | iterating a shift, one bit per cycle
// DONE   | result held until consumed (o_valid=1)
module iterative_alu #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [3:0]        i_alu_op,
  input  logic [XLEN-1:0]   i_op_a,
  input  logic [XLEN-1:0]   i_op_b,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [XLEN-1:0]   o_result,
  output logic              o_zero
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLTU = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;

  // The low two opcode bits select the shift type (00 SLL, 01 SRL, 10 SRA).
  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;

  logic [1:0]         state_q, state_d;
  logic [XLEN-1:0]    work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]         sop_q, sop_d;
  logic [XLEN-1:0]    result_q, result_d;
  logic               zero_q, zero_d;

  logic [XLEN-1:0]    alu_res;
  logic               is_shift;

  assign o_ready  = (state_q == ST_IDLE);
  assign o_valid  = (state_q == ST_DONE);
  assign o_result = result_q;
  assign o_zero   = zero_q;

  assign is_shift = (i_alu_op == OP_SLL) || (i_alu_op == OP_SRL) ||
                    (i_alu_op == OP_SRA);

  // Single-cycle result for every non-shift opcode; unused codes give 0.
  always_comb begin
    alu_res = '0;
    case (i_alu_op)
      OP_ADD:  alu_res = i_op_a + i_op_b;
      OP_SUB:  alu_res = i_op_a - i_op_b;
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (i_op_a < i_op_b)};
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(i_op_a) < $signed(i_op_b))};
      OP_AND:  alu_res = i_op_a & i_op_b;
      OP_OR:   alu_res = i_op_a | i_op_b;
      OP_XOR:  alu_res = i_op_a ^ i_op_b;
      default: alu_res = '0;
    endcase
  end

  // Next-state logic: accept, iterate shifts, hold the result until taken.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    sop_d    = sop_q;
    result_d = result_q;
    zero_d   = zero_q;
    if (i_flush) begin
      // Flush wins over both a new request and the result handshake.
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid) begin
            if (is_shift) begin
              work_d  = i_op_a;
              cnt_d   = i_op_b[SHAMT_W-1:0];
              sop_d   = i_alu_op[1:0];
              state_d = ST_SHIFT;
            end else begin
              result_d = alu_res;
              zero_d   = (alu_res == '0);
              state_d  = ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          if (cnt_q != '0) begin
            case (sop_q)
              SH_SLL:  work_d = {work_q[XLEN-2:0], 1'b0};
              SH_SRL:  work_d = {1'b0, work_q[XLEN-1:1]};
              SH_SRA:  work_d = {work_q[XLEN-1], work_q[XLEN-1:1]};
              default: work_d = work_q;
            endcase
            cnt_d = cnt_q - SHAMT_W'(1);
          end else begin
            result_d = work_q;
            zero_d   = (work_q == '0);
            state_d  = ST_DONE;
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers; reset discards any in-flight shift and clears the result.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      work_q   <= '0;
      cnt_q    <= '0;
      sop_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      sop_q    <= sop_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

endmodule

// File: tb/tb_iterative_alu.sv
// Directed bench for iterative_alu. Inputs change on the falling edge and
// outputs are sampled on the falling edge, away from the active rising edge.
module tb_iterative_alu;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic        o_ready;
  logic [3:0]  i_alu_op;
  logic [31:0] i_op_a;
  logic [31:0] i_op_b;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic        o_zero;

  int total = 0;
  int bad   = 0;
  int cyc;

  iterative_alu #(.XLEN(32), .SHAMT_W(5)) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_alu_op (i_alu_op),
    .i_op_a   (i_op_a),
    .i_op_b   (i_op_b),
    .i_flush  (i_flush),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_zero   (o_zero)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request for exactly one edge (E0), then scramble the inputs so
  // any late capture would be visible. Returns at the falling edge after E0.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    i_valid  = 1'b1;
    i_alu_op = op;
    i_op_a   = a;
    i_op_b   = b;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid  = 1'b0;
    i_alu_op = 4'b0000;
    i_op_a   = 32'hDEAD_BEEF;
    i_op_b   = 32'h1234_5677;
  endtask

  // Consume the result with a one-cycle i_ready pulse.
  task automatic take();
    i_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_ready = 1'b0;
  endtask

  // Count edges after E0 until o_valid rises, bounded.
  task automatic wait_valid(output int n);
    n = 0;
    while (!o_valid && n < 100) begin
      @(posedge i_clk);
      @(negedge i_clk);
      n++;
    end
  endtask

  initial begin
    i_reset  = 1'b1;
    i_valid  = 1'b0;
    i_alu_op = 4'b0000;
    i_op_a   = '0;
    i_op_b   = '0;
    i_flush  = 1'b0;
    i_ready  = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;

    chk("rst_ready",  32'(o_ready),  32'd1);
    chk("rst_valid",  32'(o_valid),  32'd0);
    chk("rst_result", o_result,      32'h0);
    chk("rst_zero",   32'(o_zero),   32'd1);

    // ADD with signed overflow wrap
    issue(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001);
    chk("add_valid",  32'(o_valid),  32'd1);
    chk("add_ready",  32'(o_ready),  32'd0);
    chk("add_result", o_result,      32'h8000_0000);
    chk("add_zero",   32'(o_zero),   32'd0);
    take();
    chk("take_valid", 32'(o_valid),  32'd0);
    chk("take_ready", 32'(o_ready),  32'd1);

    // SUB to zero
    issue(4'b0001, 32'd5, 32'd5);
    chk("sub_result", o_result,      32'h0);
    chk("sub_zero",   32'(o_zero),   32'd1);
    take();

    // Signed vs unsigned compare
    issue(4'b0011, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("slt_result", o_result,      32'd1);
    chk("slt_zero",   32'(o_zero),   32'd0);
    take();
    issue(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("sltu_result", o_result,     32'd0);
    chk("sltu_zero",  32'(o_zero),   32'd1);
    take();

    // Unused opcode completes in one cycle with 0
    issue(4'b0111, 32'd3, 32'd4);
    chk("unused_valid",  32'(o_valid), 32'd1);
    chk("unused_result", o_result,     32'h0);
    take();

    // Logic ops
    issue(4'b1000, 32'hF0F0_0000, 32'hFF00_00FF);
    chk("and_result", o_result, 32'hF000_0000);
    take();
    issue(4'b1001, 32'hF0F0_0000, 32'hFF00_00FF);
    chk("or_result",  o_result, 32'hFFF0_00FF);
    take();
    issue(4'b1010, 32'hF0F0_0000, 32'hFF00_00FF);
    chk("xor_result", o_result, 32'h0FF0_00FF);
    take();

    // SRA by 31: o_valid after E32
    issue(4'b0110, 32'h8000_0000, 32'd31);
    chk("sra_busy_valid", 32'(o_valid), 32'd0);
    chk("sra_busy_ready", 32'(o_ready), 32'd0);
    wait_valid(cyc);
    chk("sra_latency", 32'(cyc),  32'd32);
    chk("sra_result",  o_result,  32'hFFFF_FFFF);
    take();

    // SRL by 31
    issue(4'b0101, 32'h8000_0000, 32'd31);
    wait_valid(cyc);
    chk("srl_latency", 32'(cyc),  32'd32);
    chk("srl_result",  o_result,  32'h0000_0001);
    take();

    // SLL by 0: result after E1
    issue(4'b0100, 32'h0000_0001, 32'd0);
    wait_valid(cyc);
    chk("sll0_latency", 32'(cyc), 32'd1);
    chk("sll0_result",  o_result, 32'h0000_0001);
    take();

    // SLL with upper bits of B set: only the low 5 bits (4) count
    issue(4'b0100, 32'h0000_0001, 32'h0000_0024);
    wait_valid(cyc);
    chk("sllm_latency", 32'(cyc), 32'd5);
    chk("sllm_result",  o_result, 32'h0000_0010);
    take();

    // Backpressure: hold result 5 cycles while inputs wiggle
    issue(4'b0000, 32'd3, 32'd4);
    i_valid  = 1'b1;
    i_alu_op = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid",  32'(o_valid), 32'd1);
      chk("bp_ready",  32'(o_ready), 32'd0);
      chk("bp_result", o_result,     32'd7);
      @(posedge i_clk);
      @(negedge i_clk);
      i_op_a = i_op_a + 32'd1;
    end
    i_valid = 1'b0;
    take();
    chk("bp_rel_ready",  32'(o_ready), 32'd1);
    chk("bp_rel_valid",  32'(o_valid), 32'd0);
    chk("bp_rel_result", o_result,     32'd7);

    // Flush on the third edge of an SLL by 10, with a competing request
    issue(4'b0100, 32'h0000_0001, 32'd10);
    @(posedge i_clk);
    @(negedge i_clk);
    chk("fl_e1_valid", 32'(o_valid), 32'd0);
    @(posedge i_clk);
    @(negedge i_clk);
    chk("fl_e2_valid", 32'(o_valid), 32'd0);
    i_flush  = 1'b1;
    i_valid  = 1'b1;
    i_alu_op = 4'b0000;
    i_op_a   = 32'd10;
    i_op_b   = 32'd20;
    @(posedge i_clk);
    @(negedge i_clk);
    i_flush = 1'b0;
    chk("fl_ready", 32'(o_ready), 32'd1);
    chk("fl_valid", 32'(o_valid), 32'd0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    chk("fl_add_valid",  32'(o_valid), 32'd1);
    chk("fl_add_result", o_result,     32'd30);
    take();

    // Asynchronous reset mid-shift
    issue(4'b0110, 32'h8000_0000, 32'd20);
    repeat (3) begin
      @(posedge i_clk);
      @(negedge i_clk);
    end
    #2 i_reset = 1'b1;
    #1;
    chk("ar_valid",  32'(o_valid), 32'd0);
    chk("ar_ready",  32'(o_ready), 32'd1);
    chk("ar_result", o_result,     32'h0);
    chk("ar_zero",   32'(o_zero),  32'd1);
    @(negedge i_clk);
    i_reset = 1'b0;
    issue(4'b0000, 32'd1, 32'd1);
    chk("ar_add_valid",  32'(o_valid), 32'd1);
    chk("ar_add_result", o_result,     32'd2);
    take();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
